// File: rtl/sram_like_pkg.sv
// ------------------------------------------------------------------
// sram_like_pkg: shared size encodings and FSM state type
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package sram_like_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sram_be_gen.sv
// ------------------------------------------------------------------
// sram_be_gen: byte-lane enables and alignment check for one request
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sram_be_gen
  import sram_like_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  input  logic       wr,
  output logic [3:0] we,
  output logic       misaligned
);

  logic [3:0] w_lanes;

  always_comb begin
    w_lanes    = 4'b0000;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: w_lanes = 4'b0001 << addr_lo;
      SZ_HALF: begin
        w_lanes    = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      SZ_WORD: begin
        w_lanes    = 4'b1111;
        misaligned = |addr_lo;
      end
      default: misaligned = 1'b1;
    endcase
    we = (wr && !misaligned) ? w_lanes : 4'b0000;
  end

endmodule

`default_nettype wire

// File: rtl/sram_like_slave.sv
// ------------------------------------------------------------------
// sram_like_slave: SRAM-style req/addr_ok/data_ok slave over a sync RAM
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sram_like_slave
  import sram_like_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [3:0] c_wait_init = (LATENCY > 2) ? 4'(LATENCY - 3) : 4'd0;

  state_t             r_state, w_next;
  logic [3:0]         r_cnt, w_cnt_next;
  logic               r_wr;
  logic [1:0]         r_size;
  logic [ADDR_W+1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic [3:0]         w_we;
  logic               w_misaligned;
  logic               w_accept;
  logic [31:0]        w_rd_src;
  logic [31:0]        w_resp_rdata;
  logic               w_unused_addr;

  // Address bits above the RAM window alias onto it.
  assign w_unused_addr = &{1'b0, addr[31:ADDR_W+2]};
  assign w_accept      = !rst && req && (r_state == ST_IDLE || r_state == ST_RESP);

  sram_be_gen u_be_gen (
    .size       (r_size),
    .addr_lo    (r_addr[1:0]),
    .wr         (r_wr),
    .we         (w_we),
    .misaligned (w_misaligned)
  );

  generate
    if (LATENCY == 2) begin : g_bypass
      assign w_rd_src = ram_rdata;
    end else begin : g_capture
      logic [31:0] r_cap;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cap <= '0;
        end else if (r_state == ST_WAIT && r_cnt == c_wait_init) begin
          r_cap <= ram_rdata;
        end
      end
      assign w_rd_src = r_cap;
    end
  endgenerate

  assign w_resp_rdata = w_misaligned ? 32'h0 : (r_wr ? r_rdata : w_rd_src);

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      ST_IDLE:   if (req) w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (LATENCY > 2) begin
          w_next     = ST_WAIT;
          w_cnt_next = c_wait_init;
        end else begin
          w_next = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) w_next = ST_RESP;
        else               w_cnt_next = r_cnt - 4'd1;
      end
      ST_RESP:   w_next = req ? ST_ACCESS : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_size  <= SZ_BYTE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_wr    <= wr;
        r_size  <= size;
        r_addr  <= addr[ADDR_W+1:0];
        r_wdata <= wdata;
      end
      if (r_state == ST_RESP) r_rdata <= w_resp_rdata;
    end
  end

  // Outputs are gated by rst so an in-flight request cannot touch the RAM.
  always_comb begin
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    err       = 1'b0;
    rdata     = 32'h0;
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = 32'h0;
    if (!rst) begin
      rdata = r_rdata;
      case (r_state)
        ST_IDLE:   addr_ok = 1'b1;
        ST_ACCESS: begin
          ram_en    = !w_misaligned;
          ram_we    = w_we;
          ram_addr  = r_addr[ADDR_W+1:2];
          ram_wdata = r_wdata;
        end
        ST_RESP: begin
          addr_ok = 1'b1;
          data_ok = 1'b1;
          err     = w_misaligned;
          rdata   = w_resp_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_like_slave.sv
// ------------------------------------------------------------------
// tb_sram_like_slave: directed self-checking bench, LATENCY 2 and 5
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_sram_like_slave;
  import sram_like_pkg::*;

  logic        clk;
  int          checks;
  int          failures;

  // LATENCY = 2 instance
  logic        rst, req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok, err, ram_en;
  logic [31:0] rdata, ram_wdata, ram_rdata;
  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] mem [0:4095];

  // LATENCY = 5 instance
  logic        rst5, req5, wr5;
  logic [1:0]  size5;
  logic [31:0] addr5, wdata5;
  logic        addr_ok5, data_ok5, err5, ram_en5;
  logic [31:0] rdata5, ram_wdata5, ram_rdata5;
  logic [3:0]  ram_we5;
  logic [11:0] ram_addr5;
  logic [31:0] mem5 [0:4095];

  sram_like_slave #(.ADDR_W(12), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .err(err), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  sram_like_slave #(.ADDR_W(12), .LATENCY(5)) dut5 (
    .clk(clk), .rst(rst5), .req(req5), .wr(wr5), .size(size5), .addr(addr5),
    .wdata(wdata5), .addr_ok(addr_ok5), .data_ok(data_ok5), .rdata(rdata5),
    .err(err5), .ram_en(ram_en5), .ram_we(ram_we5), .ram_addr(ram_addr5),
    .ram_wdata(ram_wdata5), .ram_rdata(ram_rdata5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  always @(posedge clk) begin
    if (ram_en5) begin
      for (int j = 0; j < 4; j++)
        if (ram_we5[j]) mem5[ram_addr5][8*j +: 8] <= ram_wdata5[8*j +: 8];
      ram_rdata5 <= mem5[ram_addr5];
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  // One transaction on the LATENCY=2 instance, starting in an accepting cycle.
  task automatic xfer(input string nm, input logic w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ewe, input logic een, input logic [11:0] ea,
                      input logic [31:0] erd, input logic eerr);
    checks++;
    if (addr_ok !== 1'b1) begin failures++; $display("FAIL %s addr_ok_T got=%b exp=1", nm, addr_ok); end
    req = 1'b1; wr = w; size = sz; addr = a; wdata = wd;
    step();
    req = 1'b0; wr = 1'b0; size = SZ_BYTE; addr = 32'h0; wdata = 32'h0;
    checks++;
    if (ram_en !== een) begin failures++; $display("FAIL %s ram_en got=%b exp=%b", nm, ram_en, een); end
    checks++;
    if (ram_we !== ewe) begin failures++; $display("FAIL %s ram_we got=%b exp=%b", nm, ram_we, ewe); end
    checks++;
    if (addr_ok !== 1'b0 || data_ok !== 1'b0) begin
      failures++; $display("FAIL %s access_hs got addr_ok=%b data_ok=%b exp 0/0", nm, addr_ok, data_ok);
    end
    if (een) begin
      checks++;
      if (ram_addr !== ea) begin failures++; $display("FAIL %s ram_addr got=%h exp=%h", nm, ram_addr, ea); end
      if (w) begin
        checks++;
        if (ram_wdata !== wd) begin failures++; $display("FAIL %s ram_wdata got=%h exp=%h", nm, ram_wdata, wd); end
      end
    end
    step();
    checks++;
    if (data_ok !== 1'b1) begin failures++; $display("FAIL %s data_ok got=%b exp=1", nm, data_ok); end
    checks++;
    if (err !== eerr) begin failures++; $display("FAIL %s err got=%b exp=%b", nm, err, eerr); end
    checks++;
    if (rdata !== erd) begin failures++; $display("FAIL %s rdata got=%h exp=%h", nm, rdata, erd); end
    step();
    checks++;
    if (data_ok !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL %s idle_after got data_ok=%b err=%b exp 0/0", nm, data_ok, err);
    end
  endtask

  task automatic test_reset;
    step(); step();
    checks++;
    if (addr_ok !== 1'b0 || data_ok !== 1'b0 || err !== 1'b0 || ram_en !== 1'b0 || ram_we !== 4'b0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got addr_ok=%b data_ok=%b err=%b ram_en=%b ram_we=%b rdata=%h exp all 0",
               addr_ok, data_ok, err, ram_en, ram_we, rdata);
    end
    rst = 1'b0;
    step();
    checks++;
    if (addr_ok !== 1'b1 || data_ok !== 1'b0) begin
      failures++; $display("FAIL reset_release got addr_ok=%b data_ok=%b exp 1/0", addr_ok, data_ok);
    end
  endtask

  task automatic test_word;
    xfer("word_wr", 1'b1, SZ_WORD, 32'h10, 32'hCAFEBABE, 4'b1111, 1'b1, 12'h004, 32'h0, 1'b0);
    xfer("word_rd", 1'b0, SZ_WORD, 32'h10, 32'h0, 4'b0000, 1'b1, 12'h004, 32'hCAFEBABE, 1'b0);
  endtask

  task automatic test_byte;
    xfer("byte_pre", 1'b1, SZ_WORD, 32'h10, 32'h11223344, 4'b1111, 1'b1, 12'h004, 32'hCAFEBABE, 1'b0);
    xfer("byte_wr", 1'b1, SZ_BYTE, 32'h13, 32'h5A000000, 4'b1000, 1'b1, 12'h004, 32'hCAFEBABE, 1'b0);
    xfer("byte_rd", 1'b0, SZ_WORD, 32'h10, 32'h0, 4'b0000, 1'b1, 12'h004, 32'h5A223344, 1'b0);
  endtask

  task automatic test_half;
    xfer("half_hi_wr", 1'b1, SZ_HALF, 32'h12, 32'hBEEF0000, 4'b1100, 1'b1, 12'h004, 32'h5A223344, 1'b0);
    xfer("half_lo_wr", 1'b1, SZ_HALF, 32'h18, 32'h00007777, 4'b0011, 1'b1, 12'h006, 32'h5A223344, 1'b0);
    xfer("half_hi_rd", 1'b0, SZ_WORD, 32'h10, 32'h0, 4'b0000, 1'b1, 12'h004, 32'hBEEF3344, 1'b0);
    xfer("half_lo_rd", 1'b0, SZ_WORD, 32'h18, 32'h0, 4'b0000, 1'b1, 12'h006, 32'h00007777, 1'b0);
  endtask

  task automatic test_reject;
    xfer("rej_half_rd", 1'b0, SZ_HALF, 32'h21, 32'h0, 4'b0000, 1'b0, 12'h000, 32'h0, 1'b1);
    xfer("rej_size3", 1'b0, SZ_ILL, 32'h20, 32'h0, 4'b0000, 1'b0, 12'h000, 32'h0, 1'b1);
    xfer("rej_word_wr", 1'b1, SZ_WORD, 32'h12, 32'hFFFFFFFF, 4'b0000, 1'b0, 12'h000, 32'h0, 1'b1);
    xfer("rej_unchanged", 1'b0, SZ_WORD, 32'h10, 32'h0, 4'b0000, 1'b1, 12'h004, 32'hBEEF3344, 1'b0);
  endtask

  task automatic test_alias;
    xfer("alias_rd", 1'b0, SZ_WORD, 32'h4010, 32'h0, 4'b0000, 1'b1, 12'h004, 32'hBEEF3344, 1'b0);
    xfer("alias_wr", 1'b1, SZ_WORD, 32'h80000014, 32'h55AA55AA, 4'b1111, 1'b1, 12'h005, 32'hBEEF3344, 1'b0);
    xfer("alias_chk", 1'b0, SZ_WORD, 32'h14, 32'h0, 4'b0000, 1'b1, 12'h005, 32'h55AA55AA, 1'b0);
  endtask

  // Write then read with req held high; inputs changed during ACCESS must be ignored.
  task automatic test_back_to_back;
    req = 1'b1; wr = 1'b1; size = SZ_WORD; addr = 32'h20; wdata = 32'h01020304;
    step();
    wr = 1'b0; wdata = 32'h0;
    checks++;
    if (ram_we !== 4'b1111 || ram_wdata !== 32'h01020304 || ram_addr !== 12'h008 || addr_ok !== 1'b0) begin
      failures++;
      $display("FAIL b2b_access got we=%b wdata=%h addr=%h addr_ok=%b exp 1111/01020304/008/0",
               ram_we, ram_wdata, ram_addr, addr_ok);
    end
    step();
    checks++;
    if (data_ok !== 1'b1 || addr_ok !== 1'b1 || err !== 1'b0 || rdata !== 32'h55AA55AA) begin
      failures++;
      $display("FAIL b2b_wr_resp got data_ok=%b addr_ok=%b err=%b rdata=%h exp 1/1/0/55aa55aa",
               data_ok, addr_ok, err, rdata);
    end
    step();
    req = 1'b0;
    checks++;
    if (ram_en !== 1'b1 || ram_we !== 4'b0000 || ram_addr !== 12'h008 || data_ok !== 1'b0) begin
      failures++;
      $display("FAIL b2b_rd_access got en=%b we=%b addr=%h data_ok=%b exp 1/0000/008/0",
               ram_en, ram_we, ram_addr, data_ok);
    end
    step();
    checks++;
    if (data_ok !== 1'b1 || rdata !== 32'h01020304) begin
      failures++; $display("FAIL b2b_rd_resp got data_ok=%b rdata=%h exp 1/01020304", data_ok, rdata);
    end
    step();
  endtask

  // Reset lands in the ACCESS cycle of a write: the write must never reach the RAM.
  task automatic test_reset_in_access;
    req = 1'b1; wr = 1'b1; size = SZ_WORD; addr = 32'h10; wdata = 32'hDEADBEEF;
    step();
    req = 1'b0; wr = 1'b0; rst = 1'b1;
    #1;
    checks++;
    if (ram_en !== 1'b0 || ram_we !== 4'b0000 || data_ok !== 1'b0 || addr_ok !== 1'b0) begin
      failures++;
      $display("FAIL rst_access got en=%b we=%b data_ok=%b addr_ok=%b exp 0/0000/0/0",
               ram_en, ram_we, data_ok, addr_ok);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (addr_ok !== 1'b1 || data_ok !== 1'b0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_access_release got addr_ok=%b data_ok=%b rdata=%h exp 1/0/0", addr_ok, data_ok, rdata);
    end
    step();
    checks++;
    if (data_ok !== 1'b0) begin failures++; $display("FAIL rst_access_no_resp got data_ok=%b exp 0", data_ok); end
    xfer("rst_access_mem", 1'b0, SZ_WORD, 32'h10, 32'h0, 4'b0000, 1'b1, 12'h004, 32'hBEEF3344, 1'b0);
  endtask

  // LATENCY=5 with req held high: one response every 5 cycles.
  task automatic test_latency5;
    @(negedge clk);
    rst5 = 1'b0; req5 = 1'b1; wr5 = 1'b0; size5 = SZ_WORD; addr5 = 32'h0; wdata5 = 32'h0;
    #1;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (addr_ok5 !== (k % 5 == 0)) begin
        failures++; $display("FAIL lat5_addr_ok cycle=%0d got=%b exp=%b", k, addr_ok5, (k % 5 == 0));
      end
      checks++;
      if (data_ok5 !== (k != 0 && k % 5 == 0)) begin
        failures++; $display("FAIL lat5_data_ok cycle=%0d got=%b exp=%b", k, data_ok5, (k != 0 && k % 5 == 0));
      end
      checks++;
      if (ram_en5 !== (k % 5 == 1)) begin
        failures++; $display("FAIL lat5_ram_en cycle=%0d got=%b exp=%b", k, ram_en5, (k % 5 == 1));
      end
      if (k != 0 && k % 5 == 0) begin
        checks++;
        if (rdata5 !== 32'hA5A50F0F || err5 !== 1'b0) begin
          failures++; $display("FAIL lat5_rdata cycle=%0d got=%h err=%b exp a5a50f0f/0", k, rdata5, err5);
        end
      end
      if (k == 15) req5 = 1'b0;
      step();
    end
  endtask

  // Reset asserted during WAIT of a write on the LATENCY=5 instance.
  task automatic test_reset_in_wait;
    req5 = 1'b1; wr5 = 1'b1; size5 = SZ_WORD; addr5 = 32'h8; wdata5 = 32'h12345678;
    step();
    req5 = 1'b0; wr5 = 1'b0;
    step();
    rst5 = 1'b1;
    #1;
    checks++;
    if (data_ok5 !== 1'b0 || addr_ok5 !== 1'b0 || ram_en5 !== 1'b0) begin
      failures++;
      $display("FAIL rst_wait_during got data_ok=%b addr_ok=%b en=%b exp 0/0/0", data_ok5, addr_ok5, ram_en5);
    end
    step();
    rst5 = 1'b0;
    #1;
    checks++;
    if (addr_ok5 !== 1'b1) begin failures++; $display("FAIL rst_wait_addr_ok got=%b exp=1", addr_ok5); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (data_ok5 !== 1'b0 || err5 !== 1'b0) begin
        failures++; $display("FAIL rst_wait_no_resp cycle=%0d got data_ok=%b err=%b exp 0/0", k, data_ok5, err5);
      end
      step();
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = SZ_BYTE; addr = 32'h0; wdata = 32'h0;
    rst5 = 1'b1; req5 = 1'b0; wr5 = 1'b0; size5 = SZ_BYTE; addr5 = 32'h0; wdata5 = 32'h0;
    ram_rdata = 32'h0; ram_rdata5 = 32'h0;
    for (int m = 0; m < 4096; m++) begin
      mem[m]  = 32'h0;
      mem5[m] = 32'h0;
    end
    mem5[0] = 32'hA5A50F0F;

    test_reset();
    test_word();
    test_byte();
    test_half();
    test_reject();
    test_alias();
    test_back_to_back();
    test_reset_in_access();
    test_latency5();
    test_reset_in_wait();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
